// File: rtl/bitfused_pkg.sv
// Shared definitions for the bit-fusion PE array: precision codes, FSM state
// type, and the role functions that map a local PE index to its sign/shift.
package bitfused_pkg;

    localparam logic [1:0] P_1B = 2'b00;
    localparam logic [1:0] P_2B = 2'b01;
    localparam logic [1:0] P_4B = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StDone
    } state_e;

    function automatic logic legal_code(input logic [1:0] code);
        return (code == P_1B) || (code == P_2B) || (code == P_4B);
    endfunction

    // The PE holding the top slice of a multi-slice operand carries its sign.
    function automatic logic role_sign_act(input logic [1:0] code_a, input int unsigned q);
        int unsigned a_n;
        a_n = 32'd1 << code_a;
        return (a_n > 1) && ((q % a_n) == a_n - 1);
    endfunction

    function automatic logic role_sign_w(input logic [1:0] code_a, input logic [1:0] code_w,
                                         input int unsigned q);
        int unsigned a_n;
        int unsigned w_n;
        a_n = 32'd1 << code_a;
        w_n = 32'd1 << code_w;
        return (w_n > 1) && (((q / a_n) % w_n) == w_n - 1);
    endfunction

    function automatic logic [2:0] role_shift(input logic [1:0] code_a, input logic [1:0] code_w,
                                              input int unsigned q);
        int unsigned a_n;
        int unsigned w_n;
        a_n = 32'd1 << code_a;
        w_n = 32'd1 << code_w;
        return 3'((q % a_n) + ((q / a_n) % w_n));
    endfunction

    // Full-precision beat sum: PE dot width + max shift of 6 + tree growth.
    function automatic int unsigned sum_width(input int unsigned n_dot, input int unsigned pe_row);
        return $clog2(n_dot) + 2 + 6 + $clog2(pe_row);
    endfunction

endpackage

// File: rtl/bitfused_pe.sv
// One bit-fusion PE: N_DOT-lane 1-bit AND/popcount, signed by its role, then
// shifted to its slice weight. Purely combinational.
//   i_act, i_weight : lane bit slices
//   i_code_a/_w     : latched precision codes of the current job
//   o_term          : signed, shifted dot product
module bitfused_pe
    import bitfused_pkg::*;
#(
    parameter int unsigned N_DOT = 4,
    parameter int unsigned Q     = 0,
    localparam int unsigned DOT_W  = $clog2(N_DOT) + 2,
    localparam int unsigned TERM_W = DOT_W + 6
) (
    input  logic [N_DOT-1:0]         i_act,
    input  logic [N_DOT-1:0]         i_weight,
    input  logic [1:0]               i_code_a,
    input  logic [1:0]               i_code_w,
    output logic signed [TERM_W-1:0] o_term
);

    logic [DOT_W-1:0]         pop;
    logic signed [DOT_W-1:0]  dot;
    logic signed [TERM_W-1:0] dot_ext;
    logic                     neg;
    logic [2:0]               shift;

    always_comb begin
        pop = '0;
        for (int d = 0; d < N_DOT; d++) begin
            pop = pop + DOT_W'(i_act[d] & i_weight[d]);
        end
        neg     = role_sign_act(i_code_a, Q) ^ role_sign_w(i_code_a, i_code_w, Q);
        shift   = role_shift(i_code_a, i_code_w, Q);
        dot     = neg ? -$signed(pop) : $signed(pop);
        dot_ext = TERM_W'(dot);
        o_term  = dot_ext <<< shift;
    end

endmodule

// File: rtl/bitfused_pe_array.sv
// Bit-fusion dot-product engine: PE_ROW PEs of N_DOT lanes, per-job precision,
// length and bias, 3-stage pipeline (beat reg, beat-sum reg, saturating acc).
//   CLK/RST             : clock, synchronous active-high reset
//   i_Start/i_Precision/i_Len/i_Bias : job request, sampled only in IDLE
//   i_Valid/o_Ready/i_Act/i_Weight   : operand beat handshake
//   o_Valid/i_Ready/o_Psum/o_Sat     : held result handshake
//   o_Busy, o_Err       : not-idle flag, rejected-start pulse
module bitfused_pe_array
    import bitfused_pkg::*;
#(
    parameter int unsigned PE_ROW    = 16,
    parameter int unsigned N_DOT     = 4,
    parameter int unsigned N_BIAS    = 16,
    parameter int unsigned BITS_PSUM = 24,
    parameter int unsigned LEN_W     = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           i_Start,
    input  logic [3:0]                     i_Precision,
    input  logic [LEN_W-1:0]               i_Len,
    input  logic signed [N_BIAS-1:0]       i_Bias,
    input  logic                           i_Valid,
    output logic                           o_Ready,
    input  logic [PE_ROW*N_DOT-1:0]        i_Act,
    input  logic [PE_ROW*N_DOT-1:0]        i_Weight,
    output logic                           o_Valid,
    input  logic                           i_Ready,
    output logic signed [BITS_PSUM-1:0]    o_Psum,
    output logic                           o_Sat,
    output logic                           o_Busy,
    output logic                           o_Err
);

    localparam int unsigned DOT_W  = $clog2(N_DOT) + 2;
    localparam int unsigned TERM_W = DOT_W + 6;
    localparam int unsigned SUM_W  = sum_width(N_DOT, PE_ROW);
    localparam int unsigned MAX_AS = (BITS_PSUM > SUM_W) ? BITS_PSUM : SUM_W;
    // One guard bit above every operand so the add and bias load never wrap.
    localparam int unsigned EXT_W  = ((MAX_AS > N_BIAS) ? MAX_AS : N_BIAS) + 1;
    localparam logic signed [EXT_W-1:0] PSUM_MAX =
        {{(EXT_W - BITS_PSUM + 1){1'b0}}, {(BITS_PSUM - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] PSUM_MIN =
        {{(EXT_W - BITS_PSUM + 1){1'b1}}, {(BITS_PSUM - 1){1'b0}}};

    // Returns {clamped, value}.
    function automatic logic [BITS_PSUM:0] clamp_psum(input logic signed [EXT_W-1:0] v);
        if (v > PSUM_MAX) return {1'b1, PSUM_MAX[BITS_PSUM-1:0]};
        if (v < PSUM_MIN) return {1'b1, PSUM_MIN[BITS_PSUM-1:0]};
        return {1'b0, v[BITS_PSUM-1:0]};
    endfunction

    state_e                      state_q, state_d;
    logic [3:0]                  prec_q, prec_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [LEN_W-1:0]            cnt_q, cnt_d;
    logic signed [BITS_PSUM-1:0] acc_q, acc_d;
    logic                        sat_q, sat_d;
    logic                        err_q, err_d;
    logic                        s1_vld_q, s1_vld_d;
    logic [PE_ROW*N_DOT-1:0]     s1_act_q, s1_act_d;
    logic [PE_ROW*N_DOT-1:0]     s1_wgt_q, s1_wgt_d;
    logic                        s2_vld_q, s2_vld_d;
    logic signed [SUM_W-1:0]     s2_sum_q, s2_sum_d;

    logic signed [TERM_W-1:0]    term [PE_ROW];
    logic signed [SUM_W-1:0]     beat_sum;
    logic [BITS_PSUM:0]          bias_clamped;
    logic [BITS_PSUM:0]          acc_clamped;
    logic                        accept;
    logic                        start_ok;

    for (genvar p = 0; p < PE_ROW; p++) begin : g_pe
        bitfused_pe #(
            .N_DOT (N_DOT),
            .Q     (p % 16)
        ) u_pe (
            .i_act    (s1_act_q[p*N_DOT +: N_DOT]),
            .i_weight (s1_wgt_q[p*N_DOT +: N_DOT]),
            .i_code_a (prec_q[3:2]),
            .i_code_w (prec_q[1:0]),
            .o_term   (term[p])
        );
    end

    always_comb begin
        beat_sum = '0;
        for (int p = 0; p < PE_ROW; p++) begin
            beat_sum = beat_sum + SUM_W'(term[p]);
        end
    end

    always_comb begin
        state_d  = state_q;
        prec_d   = prec_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        err_d    = 1'b0;

        accept   = (state_q == StAccum) && i_Valid;
        start_ok = legal_code(i_Precision[3:2]) && legal_code(i_Precision[1:0]) &&
                   (i_Len != '0);
        bias_clamped = clamp_psum(EXT_W'(i_Bias));
        acc_clamped  = clamp_psum(EXT_W'(acc_q) + EXT_W'(s2_sum_q));

        s1_vld_d = accept;
        s1_act_d = accept ? i_Act : s1_act_q;
        s1_wgt_d = accept ? i_Weight : s1_wgt_q;
        s2_vld_d = s1_vld_q;
        s2_sum_d = beat_sum;

        unique case (state_q)
            StIdle: begin
                if (i_Start) begin
                    if (start_ok) begin
                        prec_d  = i_Precision;
                        len_d   = i_Len;
                        cnt_d   = '0;
                        acc_d   = bias_clamped[BITS_PSUM-1:0];
                        sat_d   = 1'b0;
                        state_d = StAccum;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StAccum: begin
                if (accept) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) state_d = StDrain;
                end
            end
            // Stage 2 drains on the same edge that enters DONE.
            StDrain: if (!s1_vld_q) state_d = StDone;
            StDone:  if (i_Ready) state_d = StIdle;
        endcase

        // Pipeline is empty in IDLE, so this never collides with the bias load.
        if (s2_vld_q) begin
            acc_d = acc_clamped[BITS_PSUM-1:0];
            sat_d = sat_q | acc_clamped[BITS_PSUM];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            prec_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_act_q <= '0;
            s1_wgt_q <= '0;
            s2_vld_q <= 1'b0;
            s2_sum_q <= '0;
        end else begin
            state_q  <= state_d;
            prec_q   <= prec_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
            s1_vld_q <= s1_vld_d;
            s1_act_q <= s1_act_d;
            s1_wgt_q <= s1_wgt_d;
            s2_vld_q <= s2_vld_d;
            s2_sum_q <= s2_sum_d;
        end
    end

    assign o_Ready = (state_q == StAccum);
    assign o_Valid = (state_q == StDone);
    assign o_Busy  = (state_q != StIdle);
    assign o_Psum  = acc_q;
    assign o_Sat   = sat_q;
    assign o_Err   = err_q;

endmodule

// File: tb/tb_bitfused_pe_array.sv
// Directed bench for bitfused_pe_array: a default instance (24-bit psum) and an
// 8-bit psum instance share all inputs so saturation can be seen side by side.
module tb_bitfused_pe_array;

    logic               clk;
    logic               rst;
    logic               start;
    logic [3:0]         prec;
    logic [7:0]         len;
    logic signed [15:0] bias;
    logic               in_valid;
    logic [63:0]        act;
    logic [63:0]        wgt;
    logic               out_ready;

    logic               ready, valid, sat, busy, err;
    logic signed [23:0] psum;
    logic               ready8, valid8, sat8, busy8, err8;
    logic signed [7:0]  psum8;

    int n_checks;
    int n_errors;

    logic [63:0] beat_act [8];
    logic [63:0] beat_wgt [8];
    int          beat_gap [8];

    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] LANE0 = 64'h1111_1111_1111_1111;

    bitfused_pe_array u_dut (
        .CLK (clk), .RST (rst), .i_Start (start), .i_Precision (prec), .i_Len (len),
        .i_Bias (bias), .i_Valid (in_valid), .o_Ready (ready), .i_Act (act),
        .i_Weight (wgt), .o_Valid (valid), .i_Ready (out_ready), .o_Psum (psum),
        .o_Sat (sat), .o_Busy (busy), .o_Err (err)
    );

    bitfused_pe_array #(.BITS_PSUM (8)) u_dut8 (
        .CLK (clk), .RST (rst), .i_Start (start), .i_Precision (prec), .i_Len (len),
        .i_Bias (bias), .i_Valid (in_valid), .o_Ready (ready8), .i_Act (act),
        .i_Weight (wgt), .o_Valid (valid8), .i_Ready (out_ready), .o_Psum (psum8),
        .o_Sat (sat8), .o_Busy (busy8), .o_Err (err8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    // Role rule for a 16-PE, 4-lane row, written straight from the definition.
    function automatic int model_beat(input logic [3:0] pc, input logic [63:0] a,
                                      input logic [63:0] w);
        int a_n, w_n, total;
        a_n   = 1 << pc[3:2];
        w_n   = 1 << pc[1:0];
        total = 0;
        for (int q = 0; q < 16; q++) begin
            int cnt, ia, iw;
            bit neg;
            cnt = 0;
            for (int d = 0; d < 4; d++) cnt += int'(a[q*4+d] & w[q*4+d]);
            ia  = q % a_n;
            iw  = (q / a_n) % w_n;
            neg = ((a_n > 1) && (ia == a_n - 1)) != ((w_n > 1) && (iw == w_n - 1));
            total += (neg ? -cnt : cnt) * (1 << (ia + iw));
        end
        return total;
    endfunction

    task automatic start_job(input logic [3:0] p, input logic [7:0] l,
                             input logic signed [15:0] b);
        start = 1'b1;
        prec  = p;
        len   = l;
        bias  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Ends one cycle after the last accepted beat.
    task automatic send_beats(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0;
            repeat (beat_gap[k]) @(negedge clk);
            in_valid = 1'b1;
            act      = beat_act[k];
            wgt      = beat_wgt[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_ones(input int n);
        for (int k = 0; k < n; k++) begin
            beat_act[k] = ONES;
            beat_wgt[k] = ONES;
            beat_gap[k] = 0;
        end
    endtask

    task automatic wait_result(input string tag);
        int waited;
        waited = 0;
        while (!valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " valid"}, int'(valid), 1);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " idle after accept"}, int'(busy), 0);
        check({tag, " valid drop"}, int'(valid), 0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        prec      = 4'b0000;
        len       = 8'd0;
        bias      = 16'sd0;
        in_valid  = 1'b0;
        act       = '0;
        wgt       = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst ready", int'(ready), 0);
        check("rst valid", int'(valid), 0);
        check("rst psum", int'(psum), 0);
        check("rst sat", int'(sat), 0);
        check("rst busy", int'(busy), 0);
        check("rst err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        // 4b x 4b, single beat, exact latency.
        fill_ones(1);
        start_job(4'b1010, 8'd1, 16'sd0);
        check("t1 ready after start", int'(ready), 1);
        send_beats(1);
        check("t1 ready drop", int'(ready), 0);
        check("t1 valid t+1", int'(valid), 0);
        @(negedge clk);
        check("t1 valid t+2", int'(valid), 0);
        @(negedge clk);
        check("t1 valid t+3", int'(valid), 1);
        check("t1 psum model", int'(psum), model_beat(4'b1010, ONES, ONES));
        check("t1 psum hand", int'(psum), 4);
        check("t1 sat", int'(sat), 0);
        release_result("t1");

        // 1b x 1b, three back-to-back beats, negative bias.
        fill_ones(3);
        start_job(4'b0000, 8'd3, -16'sd5);
        send_beats(3);
        wait_result("t2");
        check("t2 psum", int'(psum), 187);
        check("t2 psum model", int'(psum), -5 + 3 * model_beat(4'b0000, ONES, ONES));
        check("t2 sat", int'(sat), 0);
        check("t2 psum8 clamp", int'(psum8), 127);
        check("t2 sat8", int'(sat8), 1);
        release_result("t2");

        // Rejected starts.
        start = 1'b1; prec = 4'b1100; len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        check("t3 err act11", int'(err), 1);
        check("t3 err8 act11", int'(err8), 1);
        check("t3 busy act11", int'(busy), 0);
        check("t3 ready act11", int'(ready), 0);
        @(negedge clk);
        check("t3 err pulse ends", int'(err), 0);
        start = 1'b1; prec = 4'b0011; len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        check("t3 err w11", int'(err), 1);
        check("t3 busy w11", int'(busy), 0);
        start = 1'b1; prec = 4'b0000; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("t3 err len0", int'(err), 1);
        check("t3 busy len0", int'(busy), 0);
        check("t3 ready len0", int'(ready), 0);
        @(negedge clk);

        // Saturation on the 8-bit instance, positive and negative.
        fill_ones(4);
        start_job(4'b0000, 8'd1, 16'sd120);
        send_beats(1);
        wait_result("t4a");
        check("t4a psum8", int'(psum8), 127);
        check("t4a sat8", int'(sat8), 1);
        check("t4a psum", int'(psum), 184);
        check("t4a sat", int'(sat), 0);
        release_result("t4a");
        start_job(4'b0000, 8'd4, 16'sd120);
        send_beats(4);
        wait_result("t4b");
        check("t4b psum8", int'(psum8), 127);
        check("t4b sat8", int'(sat8), 1);
        check("t4b psum", int'(psum), 376);
        release_result("t4b");
        start_job(4'b0001, 8'd1, -16'sd120);
        send_beats(1);
        wait_result("t4c");
        check("t4c psum8", int'(psum8), -128);
        check("t4c sat8", int'(sat8), 1);
        check("t4c psum", int'(psum), -152);
        check("t4c psum model", int'(psum), -120 + model_beat(4'b0001, ONES, ONES));
        check("t4c sat", int'(sat), 0);
        release_result("t4c");

        // 2b x 2b with valid gaps, held result, ignored and honoured starts.
        beat_act[0] = ONES;  beat_wgt[0] = ONES; beat_gap[0] = 0;
        beat_act[1] = ONES;  beat_wgt[1] = '0;   beat_gap[1] = 2;
        beat_act[2] = LANE0; beat_wgt[2] = ONES; beat_gap[2] = 1;
        beat_act[3] = ONES;  beat_wgt[3] = ONES; beat_gap[3] = 3;
        start_job(4'b0101, 8'd4, 16'sd10);
        send_beats(4);
        wait_result("t5");
        for (int h = 0; h < 5; h++) begin
            check("t5 hold valid", int'(valid), 1);
            check("t5 hold psum", int'(psum), 46);
            check("t5 hold busy", int'(busy), 1);
            check("t5 hold err", int'(err), 0);
            start = (h == 2);
            prec  = 4'b0000;
            len   = 8'd1;
            bias  = 16'sd0;
            @(negedge clk);
        end
        start = 1'b0;
        check("t5 psum after hold", int'(psum), 46);
        out_ready = 1'b1;
        start     = 1'b1;
        bias      = 16'sd7;
        @(negedge clk);
        out_ready = 1'b0;
        check("t5 start with ready ignored", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        check("t5 next start busy", int'(busy), 1);
        check("t5 next start ready", int'(ready), 1);
        fill_ones(1);
        send_beats(1);
        wait_result("t5b");
        check("t5b psum", int'(psum), 71);
        check("t5b sat", int'(sat), 0);
        release_result("t5b");

        // Reset in the middle of a job.
        fill_ones(2);
        start_job(4'b0000, 8'd8, 16'sd0);
        send_beats(2);
        rst      = 1'b1;
        in_valid = 1'b1;
        act      = ONES;
        wgt      = ONES;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("t6 rst ready", int'(ready), 0);
        check("t6 rst valid", int'(valid), 0);
        check("t6 rst psum", int'(psum), 0);
        check("t6 rst sat", int'(sat), 0);
        check("t6 rst busy", int'(busy), 0);
        check("t6 rst err", int'(err), 0);
        check("t6 rst ready8", int'(ready8), 0);
        check("t6 rst busy8", int'(busy8), 0);
        check("t6 rst psum8", int'(psum8), 0);
        repeat (4) @(negedge clk);
        check("t6 no late valid", int'(valid), 0);
        fill_ones(1);
        start_job(4'b0000, 8'd1, 16'sd3);
        send_beats(1);
        wait_result("t6b");
        check("t6b psum", int'(psum), 67);
        check("t6b sat", int'(sat), 0);
        check("t6b valid8", int'(valid8), 1);
        check("t6b psum8", int'(psum8), 67);
        check("t6b sat8", int'(sat8), 0);
        release_result("t6b");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
